// File: rtl/blk_mem_sin_pkg.sv
// Purpose: shared constants and elaboration-time sine helper for the sine ROM.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package blk_mem_sin_pkg;

  localparam int DEPTH    = 1000;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 10;
  localparam int MIDSCALE = 32768;
  localparam int AMPL     = 32767;

  // Quarter-wave table geometry: indices 0..DEPTH/4 inclusive.
  localparam int QTR_N  = DEPTH / 4 + 1;
  localparam int QIDX_W = 8;
  localparam int MAG_W  = 15;

  localparam real PI = 3.14159265358979323846;

  // Magnitude above midscale for quarter index i, rounded half-up.
  // Taylor series in double precision; x <= pi/2 so 12 terms are far
  // below one LSB of error.
  function automatic int quarter_mag(input int i);
    real x;
    real x2;
    real term;
    real s;
    int  v;
    x    = 2.0 * PI * i / DEPTH;
    x2   = x * x;
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x2 / ((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    v = $rtoi(AMPL * s + 0.5);
    if (v < 0)    v = 0;
    if (v > AMPL) v = AMPL;
    return v;
  endfunction

endpackage

// File: rtl/blk_mem_sin_if.sv
// Purpose: read port bundle (enable, address, data) of the sine ROM.
// Latency: n/a (wiring only).
// Backpressure: none; the ROM accepts a read on every enabled edge.
interface blk_mem_sin_if #(
  parameter int ADDR_W = blk_mem_sin_pkg::ADDR_W,
  parameter int DATA_W = blk_mem_sin_pkg::DATA_W
);
  logic              ena;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] douta;

  modport master (output ena, output addra, input douta);
  modport slave  (input ena, input addra, output douta);
endinterface

// File: rtl/blk_mem_sin_quarter.sv
// Purpose: sin_quarter_rom, 251-entry quarter-wave magnitude table (offset from midscale).
// Latency: combinational lookup, no state.
// Backpressure: none.
module sin_quarter_rom
  import blk_mem_sin_pkg::*;
(
  input  logic [QIDX_W-1:0] i_idx,
  output logic [MAG_W-1:0]  o_mag
);

  logic [MAG_W-1:0] w_rom [QTR_N];

  // Table contents are fixed at elaboration; nothing is computed at runtime.
  for (genvar g = 0; g < QTR_N; g++) begin : g_rom
    localparam logic [MAG_W-1:0] C_VAL = MAG_W'(quarter_mag(g));
    assign w_rom[g] = C_VAL;
  end

  // Indices past the quarter point cannot come from the folder; return zero.
  always_comb begin
    o_mag = '0;
    if (i_idx < QIDX_W'(QTR_N)) o_mag = w_rom[i_idx];
  end

endmodule

// File: rtl/blk_mem_sin.sv
// Purpose: one-period sine ROM built from a quarter-wave table with address folding.
// Latency: one cycle from enabled address to douta; douta holds when ena=0.
// Backpressure: none; a new address may be presented every cycle.
module blk_mem_sin #(
  parameter int DEPTH  = blk_mem_sin_pkg::DEPTH,
  parameter int DATA_W = blk_mem_sin_pkg::DATA_W,
  parameter int ADDR_W = blk_mem_sin_pkg::ADDR_W
) (
  input  logic         clka,
  input  logic         rsta_n,
  blk_mem_sin_if.slave bus
);
  import blk_mem_sin_pkg::MIDSCALE;
  import blk_mem_sin_pkg::QIDX_W;
  import blk_mem_sin_pkg::MAG_W;

  // One extra bit so DEPTH itself is representable in comparisons.
  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0]    C_DEPTH = AW1'(DEPTH);
  localparam logic [AW1-1:0]    C_HALF  = AW1'(DEPTH / 2);
  localparam logic [AW1-1:0]    C_QTR   = AW1'(DEPTH / 4);
  localparam logic [DATA_W-1:0] C_MID   = DATA_W'(MIDSCALE);

  logic [AW1-1:0]    w_a;
  logic [AW1-1:0]    w_half_off;
  logic [AW1-1:0]    w_fold;
  logic              w_neg;
  logic              w_oob;
  logic [QIDX_W-1:0] w_idx;
  logic [MAG_W-1:0]  w_mag;
  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] r_douta;

  assign w_a = {1'b0, bus.addra};

  // Fold: choose the half period (sign), then mirror its second quarter onto the first.
  always_comb begin
    w_neg      = (w_a >= C_HALF);
    w_oob      = (w_a >= C_DEPTH);
    w_half_off = w_neg ? (w_a - C_HALF) : w_a;
    w_fold     = (w_half_off > C_QTR) ? (C_HALF - w_half_off) : w_half_off;
  end

  assign w_idx = QIDX_W'(w_fold);

  sin_quarter_rom u_quarter (
    .i_idx (w_idx),
    .o_mag (w_mag)
  );

  // Apply the sign around midscale; addresses past the period read as midscale.
  always_comb begin
    if (w_oob)      w_sample = C_MID;
    else if (w_neg) w_sample = C_MID - DATA_W'(w_mag);
    else            w_sample = C_MID + DATA_W'(w_mag);
  end

  // Output register: reset wins over enable, otherwise load on ena and hold otherwise.
  always_ff @(posedge clka) begin
    if (!rsta_n)      r_douta <= C_MID;
    else if (bus.ena) r_douta <= w_sample;
  end

  assign bus.douta = r_douta;

endmodule

// File: tb/tb_blk_mem_sin.sv
// Purpose: self-checking bench for blk_mem_sin (directed vectors, sweep, mid-sweep reset).
// Latency: checks each output half a cycle after the edge that produced it.
// Backpressure: n/a.
module tb_blk_mem_sin;

  localparam int  NV = 18;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic        rst_n;
    logic        ena;
    logic [9:0]  addr;
    logic [15:0] exp;
  } vec_t;

  logic clka;
  logic rsta_n;
  int   checks;
  int   failures;
  vec_t vecs [NV];
  logic [15:0] got [1000];

  blk_mem_sin_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  blk_mem_sin #(.DEPTH(1000), .DATA_W(16), .ADDR_W(10)) dut (
    .clka   (clka),
    .rsta_n (rsta_n),
    .bus    (bus)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // Independent reference: full-period formula evaluated with $sin at run time.
  function automatic logic [15:0] model(input int a);
    real v;
    if (a >= 1000) return 16'd32768;
    v = $floor(32768.0 + 32767.0 * $sin(2.0 * PI * a / 1000.0) + 0.5);
    if (v < 0.0)     v = 0.0;
    if (v > 65535.0) v = 65535.0;
    return 16'($rtoi(v));
  endfunction

  // Drive inputs at a negedge (or time 0) and return at the next negedge.
  task automatic cycle(input logic r, input logic e, input logic [9:0] a);
    rsta_n    = r;
    bus.ena   = e;
    bus.addra = a;
    @(negedge clka);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: douta=%0d expected=%0d", nm, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs = '{
      '{1'b0, 1'b1, 10'd250,  16'd32768},  // reset with ena=1
      '{1'b1, 1'b1, 10'd250,  16'd65535},  // first read after release
      '{1'b1, 1'b1, 10'd0,    16'd32768},
      '{1'b1, 1'b1, 10'd125,  16'd55938},
      '{1'b1, 1'b1, 10'd250,  16'd65535},
      '{1'b1, 1'b1, 10'd500,  16'd32768},
      '{1'b1, 1'b1, 10'd750,  16'd1},
      '{1'b1, 1'b1, 10'd250,  16'd65535},
      '{1'b1, 1'b0, 10'd750,  16'd65535},  // hold x3
      '{1'b1, 1'b0, 10'd750,  16'd65535},
      '{1'b1, 1'b0, 10'd750,  16'd65535},
      '{1'b1, 1'b1, 10'd1000, 16'd32768},  // out of range
      '{1'b1, 1'b1, 10'd999,  16'd32562},
      '{1'b1, 1'b1, 10'd1023, 16'd32768},  // out of range
      '{1'b1, 1'b1, 10'd1,    16'd32974},
      '{1'b1, 1'b1, 10'd750,  16'd1},
      '{1'b0, 1'b0, 10'd250,  16'd32768},  // reset with ena=0
      '{1'b1, 1'b0, 10'd250,  16'd32768}   // hold reset value
    };

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst_n, vecs[i].ena, vecs[i].addr);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), bus.douta, vecs[i].exp);
    end

    // Back-to-back sweep over one full period and across the wrap to 0.
    for (int a = 0; a <= 1000; a++) begin
      cycle(1'b1, 1'b1, 10'(a % 1000));
      check($sformatf("sweep_addr%0d", a % 1000), bus.douta, model(a % 1000));
      if (a < 1000) got[a] = bus.douta;
    end

    // Quarter-wave symmetry of the values actually read back.
    for (int a = 0; a <= 250; a++)
      check($sformatf("sym_mirror_%0d", a), got[a], got[500 - a]);
    for (int a = 1; a <= 249; a++)
      check($sformatf("sym_neg_%0d", a), got[500 + a], 16'(32'd65536 - 32'(got[a])));

    // Reset pulse in the middle of a running sweep.
    for (int a = 590; a <= 610; a++) begin
      cycle((a != 600), 1'b1, 10'(a));
      check($sformatf("midrst_addr%0d", a), bus.douta,
            (a == 600) ? 16'd32768 : model(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blk_mem_sin.md
BLK_MEM_SIN -- requirements
Module: blk_mem_sin

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): DEPTH, 1000, table entries per period; DATA_W, 16, output width; ADDR_W, 10, address width.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; ports are clka and rsta_n.
REQ-003 Port clka, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 Port rsta_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port ena, input, 1 bit: read enable.
REQ-006 Port addra, input, ADDR_W bits: sample index, unsigned.
REQ-007 Port douta, output, DATA_W bits: registered sine sample, unsigned offset-binary with midscale 32768.

Function
REQ-008 Entry a (0..DEPTH-1) SHALL equal round-half-up(32768 + 32767*sin(2*pi*a/DEPTH)), clamped to 0..65535.
REQ-009 The table SHALL be computed at elaboration (constant function or generate), with no runtime arithmetic in the data path.
REQ-010 Read latency SHALL be one cycle: if ena=1 at edge N, douta after edge N equals entry(addra sampled at edge N).
REQ-011 If ena=0 at an edge, douta SHALL hold its previous value.
REQ-012 Addresses DEPTH..2^ADDR_W-1 (1000..1023 by default) SHALL return 32768 (midscale) when read.
REQ-013 The table SHALL hold exact quarter-wave symmetry: entry(a)=entry(500-a) for a in 0..250, and entry(500+a)=65536-entry(a) for a in 1..249.
REQ-014 No internal state other than the douta register SHALL exist; consecutive reads at any address sequence (including wrap 999->0) SHALL need no extra cycles.

Reset
REQ-015 When rsta_n=0 at a rising edge, douta SHALL become 32768 (0x8000), regardless of ena.
REQ-016 Reset SHALL take priority over ena; the first valid read completes on the first edge with rsta_n=1 and ena=1.
REQ-017 Reset SHALL NOT alter table contents.

Structure
REQ-018 A shared package SHALL hold DEPTH, DATA_W, ADDR_W, MIDSCALE=32768 and AMPL=32767.
REQ-019 One sub-module, sin_quarter_rom, SHALL be used: a 251-entry (0..250) quarter-wave table, 15-bit magnitude offset from midscale.
REQ-020 The top level SHALL fold the address into a quarter index and apply the sign around midscale.

Verification
REQ-021 rsta_n=0, ena=1, addra=250 for one edge -> douta=32768; release reset, read 250 -> douta=65535 one cycle later.
REQ-022 ena=1; addra=0, 125, 250, 500, 750 on consecutive edges -> douta=32768, 55938, 65535, 32768, 1, each one cycle after its address.
REQ-023 Read 250, then ena=0 with addra=750 for 3 edges -> douta stays 65535.
REQ-024 addra=1000 and addra=1023 with ena=1 -> douta=32768.
REQ-025 Sweep addra 0..999, then wrap to 0 -> each output matches the REQ-008 model and REQ-013 symmetry, with no gap at the 999->0 wrap.
REQ-026 Assert rsta_n=0 mid-sweep at address 600 -> douta=32768 on that edge; the sweep resumes correctly after release.
